// File: rtl/score_mux_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// score_pkg : 7-segment glyph table and encoder for the score display.
// Revision  : 1.0  initial release
// ---------------------------------------------------------------------------
package score_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // {g,f,e,d,c,b,a}, active-high, digits 0..9
  localparam logic [6:0] SEG_GLYPH [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  function automatic logic [6:0] seg_encode(input logic [3:0] value,
                                            input logic       blank,
                                            input logic       invert);
    logic [6:0] glyph;
    if (blank || (value > 4'd9)) glyph = SEG_BLANK;
    else                         glyph = SEG_GLYPH[value];
    return glyph ^ {7{invert}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/score_mux_bcd_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bcd_counter : DIGITS-wide BCD up-counter with ripple carry and wrap flag.
// Revision    : 1.0  initial release
// ---------------------------------------------------------------------------
module bcd_counter
  import score_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                inc,
  output logic [4*DIGITS-1:0] q,
  output logic                wrap
);

  logic [4*DIGITS-1:0] q_next;
  logic                all_nines;

  always_comb begin
    logic carry;
    carry  = 1'b1;
    q_next = q;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (q[4*i +: 4] == 4'd9) begin
          q_next[4*i +: 4] = 4'd0;
        end else begin
          q_next[4*i +: 4] = q[4*i +: 4] + 4'd1;
          carry            = 1'b0;
        end
      end
    end
    // carry surviving every digit means the counter was all 9s
    all_nines = carry;
  end

  assign wrap = inc & ~clr & all_nines;

  always_ff @(posedge clk) begin
    if (!rst_n)   q <= '0;
    else if (clr) q <= '0;
    else if (inc) q <= q_next;
  end

endmodule
`default_nettype wire

// File: rtl/score_mux.sv
`default_nettype none
// ---------------------------------------------------------------------------
// score_mux : multi-digit BCD score / high score with multiplexed 7-seg drive.
// Revision  : 1.0  initial release
// ---------------------------------------------------------------------------
module score_mux
  import score_pkg::*;
#(
  parameter int DIGITS      = 2,
  parameter int REFRESH_DIV = 1,
  parameter int BLINK_HALF  = 25_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                inc,
  input  logic                ena,
  input  logic                invert,
  input  logic                show_high,
  input  logic                lzb,
  output logic [6:0]          segments,
  output logic [DIGITS-1:0]   digits,
  output logic [4*DIGITS-1:0] score_bcd,
  output logic [4*DIGITS-1:0] high_bcd,
  output logic                new_high,
  output logic                overflow
);

  localparam int REF_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int ACT_W   = (DIGITS > 1)      ? $clog2(DIGITS)      : 1;
  localparam int BLINK_W = (BLINK_HALF > 1)  ? $clog2(BLINK_HALF)  : 1;

  logic wrap;

  bcd_counter #(.DIGITS(DIGITS)) u_score (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (inc),
    .q     (score_bcd),
    .wrap  (wrap)
  );

  // High only loads while score == high, so incrementing high equals the new score
  logic [4*DIGITS-1:0] high_inc;

  always_comb begin
    logic carry;
    carry    = 1'b1;
    high_inc = high_bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (high_bcd[4*i +: 4] == 4'd9) begin
          high_inc[4*i +: 4] = 4'd0;
        end else begin
          high_inc[4*i +: 4] = high_bcd[4*i +: 4] + 4'd1;
          carry              = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      high_bcd <= '0;
      new_high <= 1'b0;
      overflow <= 1'b0;
    end else if (clr) begin
      new_high <= 1'b0;
      overflow <= 1'b0;
    end else if (inc) begin
      if (wrap) begin
        overflow <= 1'b1;
      end else if (score_bcd == high_bcd) begin
        high_bcd <= high_inc;
        new_high <= 1'b1;
      end
    end
  end

  logic [REF_W-1:0] ref_cnt;
  logic [ACT_W-1:0] active;
  logic             ref_tc;

  assign ref_tc = (ref_cnt == REF_W'(REFRESH_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ref_cnt <= '0;
      active  <= '0;
    end else if (ref_tc) begin
      ref_cnt <= '0;
      active  <= (active == ACT_W'(DIGITS - 1)) ? '0 : active + ACT_W'(1);
    end else begin
      ref_cnt <= ref_cnt + REF_W'(1);
    end
  end

  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_W'(BLINK_HALF - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + BLINK_W'(1);
    end
  end

  logic [4*DIGITS-1:0] src;
  logic [DIGITS-1:0]   upper_zero;
  logic [DIGITS-1:0]   sel;
  logic [3:0]          cur_val;
  logic                blank;

  always_comb begin
    src = show_high ? high_bcd : score_bcd;
    // upper_zero[i]: digit i and every digit above it are zero
    upper_zero[DIGITS-1] = (src[4*(DIGITS-1) +: 4] == 4'd0);
    for (int i = DIGITS - 2; i >= 0; i--) begin
      upper_zero[i] = upper_zero[i+1] && (src[4*i +: 4] == 4'd0);
    end
    for (int i = 0; i < DIGITS; i++) begin
      sel[i] = (active == ACT_W'(i));
    end
    cur_val = src[{active, 2'b00} +: 4];
    blank   = !ena
           || (lzb && (active != '0) && upper_zero[active])
           || (new_high && !show_high && blink_phase);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      segments <= {7{invert}};
      digits   <= {DIGITS{invert}};
    end else begin
      segments <= seg_encode(cur_val, blank, invert);
      digits   <= sel ^ {DIGITS{invert}};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_score_mux.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_score_mux : self-checking bench, 2-digit and 4-digit instances.
// Revision     : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_score_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0, clr = 1'b0, inc = 1'b0;
  logic ena = 1'b1, invert = 1'b0, show_high = 1'b0, lzb = 1'b0;

  logic [6:0]  a_seg;  logic [1:0] a_dig;
  logic [7:0]  a_score, a_high;  logic a_nh, a_ov;
  logic [6:0]  b_seg;  logic [3:0] b_dig;
  logic [15:0] b_score, b_high;  logic b_nh, b_ov;

  score_mux #(.DIGITS(2), .REFRESH_DIV(1), .BLINK_HALF(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(inc), .ena(ena), .invert(invert),
    .show_high(show_high), .lzb(lzb), .segments(a_seg), .digits(a_dig),
    .score_bcd(a_score), .high_bcd(a_high), .new_high(a_nh), .overflow(a_ov));

  score_mux #(.DIGITS(4), .REFRESH_DIV(2), .BLINK_HALF(1000)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(inc), .ena(ena), .invert(invert),
    .show_high(show_high), .lzb(lzb), .segments(b_seg), .digits(b_dig),
    .score_bcd(b_score), .high_bcd(b_high), .new_high(b_nh), .overflow(b_ov));

  int n_cmp = 0, n_bad = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  logic [6:0] glyph [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  function automatic logic [31:0] to_bcd(input int n);
    logic [31:0] r = '0;
    int v = n;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int onehot_idx(input logic [3:0] d);
    int idx = -1;
    for (int i = 0; i < 4; i++) if (d == 4'(1 << i)) idx = i;
    return idx;
  endfunction

  // reference model
  int ma_score, ma_high, mb_score;
  bit ma_nh, ma_ov;

  typedef struct {
    logic [7:0]  a_score, a_high;
    logic        a_nh, a_ov;
    logic [15:0] b_score;
  } exp_t;
  exp_t sbq[$];

  task automatic model_apply(input bit c, input bit i);
    if (c) begin
      ma_score = 0; ma_nh = 0; ma_ov = 0; mb_score = 0;
    end else if (i) begin
      if (ma_score == 99) begin
        ma_score = 0; ma_ov = 1;
      end else begin
        if (ma_score == ma_high) begin ma_high = ma_score + 1; ma_nh = 1; end
        ma_score++;
      end
      mb_score = (mb_score == 9999) ? 0 : mb_score + 1;
    end
  endtask

  task automatic step(input bit c, input bit i);
    exp_t e;
    @(negedge clk);
    clr = c; inc = i;
    model_apply(c, i);
    e.a_score = to_bcd(ma_score)[7:0];
    e.a_high  = to_bcd(ma_high)[7:0];
    e.a_nh    = ma_nh;
    e.a_ov    = ma_ov;
    e.b_score = to_bcd(mb_score)[15:0];
    sbq.push_back(e);
    @(posedge clk); #1;
    clr = 1'b0; inc = 1'b0;
    e = sbq.pop_front();
    cmp("sb_a_score", {24'h0, a_score}, {24'h0, e.a_score});
    cmp("sb_a_high",  {24'h0, a_high},  {24'h0, e.a_high});
    cmp("sb_a_new_high", {31'h0, a_nh}, {31'h0, e.a_nh});
    cmp("sb_a_overflow", {31'h0, a_ov}, {31'h0, e.a_ov});
    cmp("sb_b_score", {16'h0, b_score}, {16'h0, e.b_score});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    cmp("rst_a_segments", {25'h0, a_seg}, {25'h0, {7{invert}}});
    cmp("rst_a_digits",   {30'h0, a_dig}, {30'h0, {2{invert}}});
    cmp("rst_b_digits",   {28'h0, b_dig}, {28'h0, {4{invert}}});
    cmp("rst_a_score",    {24'h0, a_score}, 32'h0);
    cmp("rst_a_high",     {24'h0, a_high},  32'h0);
    cmp("rst_a_flags",    {30'h0, a_nh, a_ov}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ma_score = 0; ma_high = 0; ma_nh = 0; ma_ov = 0; mb_score = 0;
    sbq.delete();
  endtask

  typedef struct {
    int         op;   // 0 = inc n times, 1 = clr, 2 = reset, 3 = clr+inc
    int         n;
    logic [7:0] s, h;
    logic       nh, ov;
  } vec_t;
  vec_t tbl [14];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int idx, changes, seen;
    logic [3:0]  prev;
    logic [6:0]  exp_seg;
    bit blank_hist [24];

    tbl[0]  = '{2, 0,  8'h00, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{0, 12, 8'h12, 8'h12, 1'b1, 1'b0};
    tbl[2]  = '{0, 87, 8'h99, 8'h99, 1'b1, 1'b0};
    tbl[3]  = '{0, 1,  8'h00, 8'h99, 1'b1, 1'b1};
    tbl[4]  = '{1, 0,  8'h00, 8'h99, 1'b0, 1'b0};
    tbl[5]  = '{2, 0,  8'h00, 8'h00, 1'b0, 1'b0};
    tbl[6]  = '{0, 5,  8'h05, 8'h05, 1'b1, 1'b0};
    tbl[7]  = '{1, 0,  8'h00, 8'h05, 1'b0, 1'b0};
    tbl[8]  = '{0, 3,  8'h03, 8'h05, 1'b0, 1'b0};
    tbl[9]  = '{0, 2,  8'h05, 8'h05, 1'b0, 1'b0};
    tbl[10] = '{0, 1,  8'h06, 8'h06, 1'b1, 1'b0};
    tbl[11] = '{2, 0,  8'h00, 8'h00, 1'b0, 1'b0};
    tbl[12] = '{0, 41, 8'h41, 8'h41, 1'b1, 1'b0};
    tbl[13] = '{3, 0,  8'h00, 8'h41, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    for (int t = 0; t < 14; t++) begin
      case (tbl[t].op)
        0: for (int k = 0; k < tbl[t].n; k++) step(1'b0, 1'b1);
        1: step(1'b1, 1'b0);
        2: do_reset();
        default: step(1'b1, 1'b1);
      endcase
      cmp($sformatf("tbl%0d_score", t), {24'h0, a_score}, {24'h0, tbl[t].s});
      cmp($sformatf("tbl%0d_high", t),  {24'h0, a_high},  {24'h0, tbl[t].h});
      cmp($sformatf("tbl%0d_flags", t), {30'h0, a_nh, a_ov}, {30'h0, tbl[t].nh, tbl[t].ov});
    end

    // reset mid-count with common-anode polarity: outputs must go dark-high
    invert = 1'b1;
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1);
    do_reset();
    invert = 1'b0;

    // 2-digit display of 12, steady via high-score view
    for (int k = 0; k < 12; k++) step(1'b0, 1'b1);
    @(negedge clk); show_high = 1'b1;
    prev = 4'h0;
    for (int c = 0; c < 12; c++) begin
      if (c == 6) begin @(negedge clk); invert = 1'b1; end
      @(posedge clk); #1;
      idx = onehot_idx({2'b00, a_dig ^ {2{invert}}});
      cmp("a_digit_onehot", {31'h0, idx >= 0}, 32'h1);
      if (idx == 0) exp_seg = glyph[2] ^ {7{invert}};
      else          exp_seg = glyph[1] ^ {7{invert}};
      cmp("a_glyph", {25'h0, a_seg}, {25'h0, exp_seg});
      if (c > 0 && c != 6) cmp("a_alternate", {31'h0, a_dig != prev[1:0]}, 32'h1);
      prev = {2'b00, a_dig};
    end
    cmp("a_invert_units", {23'h0, a_dig, a_seg},
        (a_dig == 2'b10) ? {23'h0, 2'b10, 7'b0100100} : {23'h0, 2'b01, 7'b1111001});
    @(negedge clk); invert = 1'b0; ena = 1'b0;
    @(posedge clk); #1;
    cmp("a_ena_blank", {25'h0, a_seg}, 32'h0);
    @(negedge clk); ena = 1'b1; show_high = 1'b0;

    // blink: 1 inc raises new_high; expect 4 blank / 4 lit repeating
    do_reset();
    step(1'b0, 1'b1);
    for (int c = 0; c < 24; c++) begin
      @(posedge clk); #1;
      blank_hist[c] = (a_seg == 7'h00);
      idx = onehot_idx({2'b00, a_dig});
      if (!blank_hist[c])
        cmp("blink_lit_glyph", {25'h0, a_seg}, {25'h0, (idx == 0) ? glyph[1] : glyph[0]});
    end
    for (int c = 0; c < 20; c++)
      cmp("blink_period", {31'h0, blank_hist[c] != blank_hist[c+4]}, 32'h1);
    @(negedge clk); show_high = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      cmp("blink_show_high_steady", {31'h0, a_seg != 7'h00}, 32'h1);
    end

    // 4-digit leading-zero blanking on 0007
    do_reset();
    for (int k = 0; k < 7; k++) step(1'b0, 1'b1);
    cmp("b_score_0007", {16'h0, b_score}, 32'h0007);
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk); lzb = (pass == 0); show_high = 1'b1;
      @(posedge clk); #1;
      prev = b_dig; changes = 0; seen = 0;
      for (int c = 0; c < 16; c++) begin
        @(posedge clk); #1;
        idx = onehot_idx(b_dig);
        cmp("b_digit_onehot", {31'h0, idx >= 0}, 32'h1);
        if (idx >= 0) seen = seen | (1 << idx);
        if (b_dig != prev) changes++;
        prev = b_dig;
        if (idx == 0)      exp_seg = glyph[7];
        else if (pass == 0) exp_seg = 7'h00;
        else                exp_seg = glyph[0];
        cmp($sformatf("b_lzb%0d_glyph", 1 - pass), {25'h0, b_seg}, {25'h0, exp_seg});
      end
      cmp("b_all_digits_seen", seen, 32'hF);
      cmp("b_refresh_changes", changes, 32'd8);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/score_mux.md
# score_mux

Parametrised multi-digit score display for the Simon game family, successor to the 2-digit `score` block. Holds a DIGITS-wide BCD score and a session high score, and drives a time-multiplexed 7-segment display. Adds leading-zero blanking, high-score view, new-record blinking and overflow reporting. Sits between the game FSM (`inc`/`clr` pulses) and the board's segment/digit pins.

## Interface

Parameters:
- `DIGITS`, 2: number of BCD digits / digit-select lines, legal range 1..8.
- `REFRESH_DIV`, 1: clock cycles each digit stays selected, ≥1.
- `BLINK_HALF`, 25_000_000: clock cycles per blink half-period, ≥1.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `clr` in 1: clears the current score, overflow and new_high; high score kept.
- `inc` in 1: one-cycle pulse, score +1 in BCD.
- `ena` in 1: display enable; 0 blanks all segments, multiplexing continues.
- `invert` in 1: 1 = common-anode polarity, inverts segments and digits.
- `show_high` in 1: display the high score instead of the current score.
- `lzb` in 1: leading-zero blanking enable.
- `segments` out 7: {g,f,e,d,c,b,a}, registered.
- `digits` out DIGITS: one-hot digit select (one-cold when `invert`), registered; bit 0 is units.
- `score_bcd` out 4*DIGITS: current score, digit i at [4i+3:4i].
- `high_bcd` out 4*DIGITS: high score.
- `new_high` out 1: high score raised since the last `clr`/reset.
- `overflow` out 1: sticky; score wrapped from all-9s to 0.

## Operation

- Reset (`rst_n`=0 at edge): score, high, active digit, refresh and blink counters = 0. `new_high`, `overflow` = 0. `segments` <= {7{invert}}, `digits` <= {DIGITS{invert}} (all dark).
- Priority: reset > `clr` > `inc`. `clr` with `inc` in the same cycle leaves score 0.
- `inc`: BCD increment with ripple carry. If all digits are 9, score wraps to 0 and `overflow` <= 1; high is unchanged.
- Otherwise, if score == high before the increment, high <= incremented score and `new_high` <= 1. Because score only steps by 1, this keeps high = max(score).
- `clr`: score, `overflow`, `new_high` <= 0, and the blink counter and phase reset. `high_bcd` is kept; only `rst_n` clears it.
- Multiplex: the refresh counter runs 0..REFRESH_DIV-1. At terminal count, active digit advances 0..DIGITS-1 and wraps to 0.
- Each cycle, the registered outputs take the active digit's select and glyph. Source value is `high_bcd` if `show_high`, else `score_bcd`.
- Glyph is blank when any of these holds:
  - `ena`=0;
  - `lzb`=1, active digit i>0, and all source digits j≥i are 0 (units digit never blanked);
  - `new_high`=1, `show_high`=0 and blink phase = 1.
  - Digit values >9 cannot occur.
- Blink: the counter runs 0..BLINK_HALF-1 and the phase toggles at terminal count. Runs continuously; affects display only.

## Timing

- `score_bcd`, `high_bcd`, `new_high`, `overflow` update on the edge that samples `inc`/`clr` (1-cycle latency).
- `segments`/`digits` lag the internal active digit and source value by 1 cycle. A score change appears on the display by the next edge after it if that digit is active.
- With REFRESH_DIV=1, DIGITS=2: `digits` alternates every cycle, matching the legacy block.
- `invert`, `ena`, `show_high`, `lzb` are combinational into the output registers, so a change takes effect 1 cycle later.
- Reset mid-refresh: the next select after release is digit 0.

## Structure

- Package `score_pkg`:
  - `SEG_GLYPH` constant: 0..9 active-high encodings;
  - `SEG_BLANK` = 7'b0000000;
  - function `seg_encode(value, blank, invert)` returning 7 bits.
- Sub-module `bcd_counter` (parameter DIGITS): `clk`, `rst_n`, `clr`, `inc`, `q`, `wrap`. Instantiated once for the score. High score is a plain load register in `score_mux`.
- Multiplexer, blink, blanking and high tracking live in `score_mux`.

## Test plan

- DIGITS=2, REFRESH_DIV=1: reset, then 12 `inc` pulses → `score_bcd`=8'h12, `high_bcd`=8'h12, `new_high`=1. Display alternates units "2" / tens "1"; `invert`=1 gives 7'b0100100 with `digits`=2'b10 on units.
- 99 `inc`, then 1 more → score 8'h00, `overflow`=1, high 8'h99. `clr` → `overflow`=0, high still 8'h99.
- After high=8'h05: `clr`, then 3 `inc` → `new_high`=0, high 8'h05. 3 more → high 8'h06 on the 6th `inc`, `new_high`=1.
- DIGITS=4, `lzb`=1, score 0007 → digits 1–3 blank, units "7". `lzb`=0 → "0" glyphs shown.
- BLINK_HALF=4, `new_high`=1, `show_high`=0 → segments blank 4 cycles, lit 4 cycles, repeating. `show_high`=1 → steady high-score glyphs.
- `clr` and `inc` together at score 8'h41 → score 8'h00. `rst_n` low mid-count → all state 0, outputs dark next edge.
